// File: rtl/ln_pkg.sv
// Shared constants and types for the natural-log datapath.
// Used by the range reducer, the polynomial stage and the combiner.
package ln_pkg;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        OUT
    } ln_state_t;

    localparam int LN_FB = 16;
    localparam int LN_W  = 17;

    // ln2 in Q0.16, used by the e*ln2 combiner
    localparam int LN2_Q16 = 45426;

    // ln(1+x) Taylor terms in Q16: x - x^2/2 + x^3/3 - x^4/4
    localparam int C1_Q16 = 65536;
    localparam int C2_Q16 = -32768;
    localparam int C3_Q16 = 21845;
    localparam int C4_Q16 = -16384;

endpackage

// File: rtl/ln_range_reduce.sv
// Leading-one normaliser: X = 2^e * (1 + m), m emitted in Q0.FB.
// One bit of left shift per cycle until the MSB is set.
module ln_range_reduce
    import ln_pkg::*;
#(
    parameter int WIN = 32,
    parameter int W   = LN_W,
    parameter int FB  = LN_FB,
    parameter int EW  = $clog2(WIN)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [WIN-1:0] x_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W:0]     frac_out,
    output logic [EW-1:0]  exp_out,
    output logic           zero_out
);

    ln_state_t      state_q, state_d;
    logic [WIN-1:0] sreg_q, sreg_d;
    logic [EW-1:0]  ecnt_q, ecnt_d;
    logic [W:0]     frac_q, frac_d;
    logic [EW-1:0]  exp_q, exp_d;
    logic           zero_q, zero_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            ecnt_q  <= '0;
            frac_q  <= '0;
            exp_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            ecnt_q  <= ecnt_d;
            frac_q  <= frac_d;
            exp_q   <= exp_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        ecnt_d  = ecnt_q;
        frac_d  = frac_q;
        exp_d   = exp_q;
        zero_d  = zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sreg_d  = x_in;
                    ecnt_d  = EW'(WIN - 1);
                    state_d = NORM;
                end
            end
            NORM: begin
                if (sreg_q == '0) begin
                    zero_d  = 1'b1;
                    frac_d  = '0;
                    exp_d   = '0;
                    state_d = OUT;
                end else if (sreg_q[WIN-1]) begin
                    // fraction bits sit just below the leading one
                    frac_d  = {{(W+1-FB){1'b0}},
                               sreg_q[WIN-2 -: FB]};
                    exp_d   = ecnt_q;
                    zero_d  = 1'b0;
                    state_d = OUT;
                end else begin
                    sreg_d = sreg_q << 1;
                    ecnt_d = ecnt_q - EW'(1);
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign frac_out  = frac_q;
    assign exp_out   = exp_q;
    assign zero_out  = zero_q;

endmodule

// File: tb/tb_ln_range_reduce.sv
// Self-checking bench for ln_range_reduce: directed table,
// stall/reset sequences and random operands against a model.
module tb_ln_range_reduce;

    localparam int WIN = 32;
    localparam int W   = 17;
    localparam int FB  = 16;
    localparam int EW  = 5;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [WIN-1:0] x_in;
    logic           out_valid;
    logic           out_ready;
    logic [W:0]     frac_out;
    logic [EW-1:0]  exp_out;
    logic           zero_out;

    int passed = 0;
    int total  = 0;

    ln_range_reduce #(
        .WIN(WIN), .W(W), .FB(FB), .EW(EW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_in     (x_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frac_out (frac_out),
        .exp_out  (exp_out),
        .zero_out (zero_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] x;
        int          e;
        int          f;
        bit          z;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s got=%0d want=%0d", nm, got, want);
    endtask

    // Reference: leading-one position, then m*2^FB by floor division.
    task automatic model(input logic [31:0] x, output int e,
                         output int f, output bit z, output int lat);
        longint r;
        e = 0;
        z = (x == 0);
        for (int i = 0; i < WIN; i++)
            if (x[i]) e = i;
        if (z) begin
            f = 0;
            lat = 2;
        end else begin
            r = (longint'(x) - (longint'(1) << e)) * (longint'(1) << FB);
            f = int'(r / (longint'(1) << e));
            lat = (WIN - 1 - e) + 2;
        end
    endtask

    // Accepts x, measures latency, optionally stalls, then drains.
    task automatic run_op(input string nm, input logic [31:0] x,
                          input int e, input int f, input bit z,
                          input int lat, input int hold);
        int n;
        logic [W:0]    sf;
        logic [EW-1:0] se;
        logic          sz;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b1;
        x_in = x;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x_in = $urandom;
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, " latency"}, n, lat);
        chk({nm, " exp"}, exp_out, e);
        chk({nm, " frac"}, frac_out, f);
        chk({nm, " zero"}, zero_out, z);
        if (hold > 0) begin
            sf = frac_out; se = exp_out; sz = zero_out;
            for (int i = 0; i < hold; i++) begin
                in_valid = (i == 1);
                x_in = 32'h0000_0001;
                @(posedge clk); #1;
                in_valid = 1'b0;
                chk({nm, " stall valid"}, out_valid, 1);
                chk({nm, " stall ready"}, in_ready, 0);
                chk({nm, " stall data"},
                    {sf, se, sz}, {frac_out, exp_out, zero_out});
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, " drained"}, {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        int e, f, lat;
        bit z;
        logic [31:0] x;

        vecs[0] = '{32'h8000_0000, 31, 0,     0, 2,  0};
        vecs[1] = '{32'h0000_0003, 1,  32768, 0, 32, 0};
        vecs[2] = '{32'h0001_2345, 16, 9029,  0, 17, 5};
        vecs[3] = '{32'h0000_0000, 0,  0,     1, 2,  0};
        vecs[4] = '{32'h0000_0001, 0,  0,     0, 33, 0};
        vecs[5] = '{32'hFFFF_FFFF, 31, 65535, 0, 2,  0};
        vecs[6] = '{32'h0000_0005, 2,  16384, 0, 31, 2};

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outs", {out_valid, frac_out, exp_out, zero_out}, 0);
        chk("reset ready", in_ready, 1);
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].e,
                   vecs[i].f, vecs[i].z, vecs[i].lat, vecs[i].hold);

        // Abort mid-normalisation; no stale result may surface.
        in_valid = 1'b1;
        x_in = 32'h0000_0010;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("abort outs", {out_valid, frac_out, exp_out, zero_out}, 0);
        chk("abort ready", in_ready, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("abort no stale", {out_valid, in_ready}, 2'b01);
        run_op("post reset", 32'd5, 2, 16384, 0, 31, 0);

        // Back-to-back with the ready stall just ignoring an early out_ready.
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("idle out_ready", {out_valid, in_ready}, 2'b01);

        for (int k = 0; k < 40; k++) begin
            x = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 9) == 0) x = 0;
            model(x, e, f, z, lat);
            run_op($sformatf("rnd%0d", k), x, e, f, z, lat,
                   $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
